dma_top: RTL and testbench

Memory subsystem with an integrated single-channel memory-to-memory DMA controller. A 1024 x 8 RAM is shared by two masters: the external processor port (addr/idata/odata/rw_) and the internal DMA engine. A simple bus arbiter uses breq_/bgrt_ to pass ownership between them. The block sits at the top of the memory/DMA hierarchy and is driven directly by the processor model.

---
 rtl/dma_top.sv | 198 +++++++++++++++++++
 tb/tb_dma_top.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_top.sv
//-----------------------------------------------------------------------------
// dma_top
//
// Memory subsystem with an integrated single-channel memory-to-memory DMA
// engine. A 2^ADDR_WIDTH x DATA_WIDTH RAM is shared between the external
// processor port and the DMA engine. A small arbiter hands the bus to the
// processor (breq_/bgrt_) or to the DMA engine (DMA_RD/DMA_WR cycles).
//
// Ports:
//   addr    in   processor address
//   idata   in   processor write data
//   odata   out  processor read data (registered, holds when not reading)
//   rw_     in   1 = read, 0 = write
//   breq_   in   processor bus request, active low
//   bgrt_   out  processor bus grant, active low
//   dsaddr  in   DMA source start address
//   ddaddr  in   DMA destination start address
//   dmode   in   2'b00 single-word mode, 2'b01 burst mode, others reserved
//   dreq_   in   DMA request, active low (a one-cycle pulse is enough)
//   eop_    out  end-of-process strobe, active low, one cycle
//   reset_  in   asynchronous active-low reset
//   clk     in   system clock
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module dma_top #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int XFER_LEN   = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] idata,
  output logic [DATA_WIDTH-1:0] odata,
  input  logic                  rw_,
  input  logic                  breq_,
  output logic                  bgrt_,
  input  logic [ADDR_WIDTH-1:0] dsaddr,
  input  logic [ADDR_WIDTH-1:0] ddaddr,
  input  logic [1:0]            dmode,
  input  logic                  dreq_,
  output logic                  eop_,
  input  logic                  reset_,
  input  logic                  clk
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CPU    = 2'd1;
  localparam logic [1:0] ST_DMA_RD = 2'd2;
  localparam logic [1:0] ST_DMA_WR = 2'd3;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Word counter only needs to reach XFER_LEN-1.
  localparam int CNT_WIDTH = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(XFER_LEN - 1);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_burst;
  logic                  r_jobActive;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_tmp;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_eop;

  logic [1:0]            w_stateNext;
  logic                  w_modeValid;
  logic                  w_newJob;
  logic                  w_nextWord;
  logic                  w_dmaWrite;
  logic                  w_lastWord;
  logic                  w_cpuWrite;
  logic                  w_cpuRead;
  logic                  w_memWe;
  logic [ADDR_WIDTH-1:0] w_memWAddr;
  logic [DATA_WIDTH-1:0] w_memWData;

  assign odata = r_odata;
  assign eop_  = r_eop;
  assign bgrt_ = (r_state != ST_CPU);

  // A request only opens a job when none is active and the mode is legal;
  // while a single-mode job is active, each further request releases one
  // more word. Requests during an active burst job fall through untouched.
  assign w_modeValid = (dmode == MODE_SINGLE) || (dmode == MODE_BURST);
  assign w_newJob    = !dreq_ && !r_jobActive && w_modeValid;
  assign w_nextWord  = !dreq_ && r_jobActive && !r_burst;
  assign w_dmaWrite  = (r_state == ST_DMA_WR);
  assign w_lastWord  = w_dmaWrite && (r_cnt == LAST_CNT);
  assign w_cpuWrite  = (r_state == ST_CPU) && (rw_ == WRITE);
  assign w_cpuRead   = (r_state == ST_CPU) && (rw_ == READ);

  // Processor wins in IDLE; once a burst has started it keeps the bus
  // until its last word, regardless of breq_.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!breq_)
          w_stateNext = ST_CPU;
        else if (r_pend)
          w_stateNext = ST_DMA_RD;
      end
      ST_CPU: begin
        if (breq_)
          w_stateNext = ST_IDLE;
      end
      ST_DMA_RD: w_stateNext = ST_DMA_WR;
      ST_DMA_WR: begin
        if (w_lastWord || !r_burst)
          w_stateNext = ST_IDLE;
        else
          w_stateNext = ST_DMA_RD;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // The single RAM write port is owned either by the DMA write cycle or by
  // a granted processor write; the two never coincide.
  always_comb begin
    w_memWe    = 1'b0;
    w_memWAddr = addr;
    w_memWData = idata;
    if (w_dmaWrite) begin
      w_memWe    = 1'b1;
      w_memWAddr = r_dst;
      w_memWData = r_tmp;
    end else if (w_cpuWrite) begin
      w_memWe = 1'b1;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_memWe)
      r_mem[w_memWAddr] <= w_memWData;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_burst     <= 1'b0;
      r_jobActive <= 1'b0;
      r_pend      <= 1'b0;
      r_tmp       <= '0;
      r_odata     <= '0;
      r_eop       <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_eop   <= 1'b1;

      if (w_cpuRead)
        r_odata <= r_mem[addr];

      if (r_state == ST_DMA_RD)
        r_tmp <= r_mem[r_src];

      // Address increments wrap naturally at the top of the RAM.
      if (w_dmaWrite) begin
        r_src <= r_src + ADDR_WIDTH'(1);
        r_dst <= r_dst + ADDR_WIDTH'(1);
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end

      // A new request arriving on the same edge that a single word
      // completes must still be honoured, so setting r_pend wins.
      if (w_lastWord) begin
        r_jobActive <= 1'b0;
        r_pend      <= 1'b0;
        r_eop       <= 1'b0;
      end else if (w_newJob) begin
        r_src       <= dsaddr;
        r_dst       <= ddaddr;
        r_burst     <= (dmode == MODE_BURST);
        r_cnt       <= '0;
        r_jobActive <= 1'b1;
        r_pend      <= 1'b1;
      end else if (w_nextWord) begin
        r_pend <= 1'b1;
      end else if (w_dmaWrite && !r_burst) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_top.sv
//-----------------------------------------------------------------------------
// tb_dma_top
//
// Self-checking bench for dma_top. A byte-array model of the RAM is updated
// on every processor write and on every DMA word the bench expects to move;
// all readbacks are compared against that model.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dma_top;

  logic       clk = 1'b0;
  logic       reset_;
  logic [9:0] addr;
  logic [7:0] idata;
  logic [7:0] odata;
  logic       rw_;
  logic       breq_;
  logic       bgrt_;
  logic [9:0] dsaddr;
  logic [9:0] ddaddr;
  logic [1:0] dmode;
  logic       dreq_;
  logic       eop_;

  logic [7:0] model [0:1023];
  int passCount  = 0;
  int checkCount = 0;

  dma_top #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .XFER_LEN(4)) dut (
    .addr(addr), .idata(idata), .odata(odata), .rw_(rw_),
    .breq_(breq_), .bgrt_(bgrt_), .dsaddr(dsaddr), .ddaddr(ddaddr),
    .dmode(dmode), .dreq_(dreq_), .eop_(eop_), .reset_(reset_), .clk(clk)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; everything is driven and sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acquireBus();
    int n;
    n = 0;
    breq_ = 1'b0;
    rw_   = 1'b1;
    tick();
    while (bgrt_ !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    checkCount++;
    if (bgrt_ !== 1'b0)
      $display("[TB] FAIL busGrant: bgrt_=%b after %0d extra cycles, required 0", bgrt_, n);
    else
      passCount++;
  endtask

  task automatic releaseBus();
    breq_ = 1'b1;
    rw_   = 1'b1;
    tick();
  endtask

  task automatic cpuWrite(input logic [9:0] a, input logic [7:0] d);
    addr  = a;
    idata = d;
    rw_   = 1'b0;
    tick();
    rw_      = 1'b1;
    model[a] = d;
  endtask

  task automatic cpuRead(input logic [9:0] a, output logic [7:0] d);
    addr = a;
    rw_  = 1'b1;
    tick();
    d = odata;
  endtask

  // One-cycle dreq_ pulse; the address/mode inputs are scrambled afterwards
  // so any later use of them by the DUT would be noticed.
  task automatic pulseDreq(input logic [9:0] s, input logic [9:0] d, input logic [1:0] m);
    dsaddr = s;
    ddaddr = d;
    dmode  = m;
    dreq_  = 1'b0;
    tick();
    dreq_  = 1'b1;
    dsaddr = 10'($urandom);
    ddaddr = 10'($urandom);
    dmode  = 2'($urandom);
  endtask

  // Word-by-word copy with 10-bit address wrap.
  task automatic modelCopy(input logic [9:0] s, input logic [9:0] d, input int n);
    logic [9:0] sa;
    logic [9:0] da;
    for (int i = 0; i < n; i++) begin
      sa = s + 10'(i);
      da = d + 10'(i);
      model[da] = model[sa];
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b1;
    breq_  = 1'b1;
    dreq_  = 1'b1;
    rw_    = 1'b1;
    addr   = '0;
    idata  = '0;
    dsaddr = '0;
    ddaddr = '0;
    dmode  = 2'b00;
    #2 reset_ = 1'b0;
    repeat (3) tick();
    checkCount++;
    if (bgrt_ !== 1'b1) $display("[TB] FAIL resetBgrt: bgrt_=%b required 1", bgrt_); else passCount++;
    checkCount++;
    if (eop_ !== 1'b1) $display("[TB] FAIL resetEop: eop_=%b required 1", eop_); else passCount++;
    checkCount++;
    if (odata !== 8'h00) $display("[TB] FAIL resetOdata: odata=%h required 00", odata); else passCount++;
    breq_ = 1'b0;
    tick();
    checkCount++;
    if (bgrt_ !== 1'b1) $display("[TB] FAIL grantInReset: bgrt_=%b required 1", bgrt_); else passCount++;
    reset_ = 1'b1;
    tick();
    checkCount++;
    if (bgrt_ !== 1'b0) $display("[TB] FAIL grantLatency: bgrt_=%b required 0", bgrt_); else passCount++;
    checkCount++;
    if (odata !== 8'h00) $display("[TB] FAIL odataAfterGrant: odata=%h required 00", odata); else passCount++;
    breq_ = 1'b1;
    tick();
    checkCount++;
    if (bgrt_ !== 1'b1) $display("[TB] FAIL releaseLatency: bgrt_=%b required 1", bgrt_); else passCount++;
  endtask

  task automatic test_cpu_rw();
    logic [9:0] rndAddr [4];
    logic [7:0] rd;
    logic [7:0] held;
    acquireBus();
    cpuWrite(10'h150, 8'h99);
    cpuWrite(10'h151, 8'h90);
    cpuWrite(10'h152, 8'h50);
    cpuWrite(10'h153, 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      rndAddr[i] = 10'h300 + 10'(i * 16) + 10'($urandom_range(0, 15));
      cpuWrite(rndAddr[i], 8'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      cpuRead(10'h150 + 10'(i), rd);
      checkCount++;
      if (rd !== model[10'h150 + 10'(i)])
        $display("[TB] FAIL cpuRead[%0d]: odata=%h required %h", i, rd, model[10'h150 + 10'(i)]);
      else passCount++;
    end
    for (int i = 0; i < 4; i++) begin
      cpuRead(rndAddr[i], rd);
      checkCount++;
      if (rd !== model[rndAddr[i]])
        $display("[TB] FAIL cpuRandRead[%0d]: odata=%h required %h", i, rd, model[rndAddr[i]]);
      else passCount++;
    end
    // Without the grant, reads must not update odata and writes must be dropped.
    releaseBus();
    held  = model[rndAddr[3]];
    addr  = 10'h151;
    idata = 8'h11;
    rw_   = 1'b0;
    repeat (2) tick();
    rw_ = 1'b1;
    tick();
    checkCount++;
    if (odata !== held) $display("[TB] FAIL odataHold: odata=%h required %h", odata, held); else passCount++;
    acquireBus();
    cpuRead(10'h151, rd);
    checkCount++;
    if (rd !== 8'h90) $display("[TB] FAIL ungrantedWrite: odata=%h required 90", rd); else passCount++;
    releaseBus();
  endtask

  task automatic test_burst();
    logic [7:0] rd;
    int eopAt;
    int eopLows;
    bit grantLeak;
    acquireBus();
    for (int i = 0; i < 8; i++) cpuWrite(10'h160 + 10'(i), 8'($urandom));
    releaseBus();
    pulseDreq(10'h150, 10'h160, 2'b01);
    eopAt = -1;
    eopLows = 0;
    grantLeak = 1'b0;
    for (int k = 2; k <= 24; k++) begin
      if (k == 5) begin
        dsaddr = 10'h100;
        ddaddr = 10'h164;
        dmode  = 2'b01;
        dreq_  = 1'b0;
      end else begin
        dreq_ = 1'b1;
      end
      tick();
      if (bgrt_ !== 1'b1) grantLeak = 1'b1;
      if (eop_ === 1'b0) begin
        eopLows++;
        if (eopAt < 0) eopAt = k;
      end
    end
    checkCount++;
    if (eopAt != 10) $display("[TB] FAIL burstEopCycle: eop_ low at cycle %0d required 10", eopAt); else passCount++;
    checkCount++;
    if (eopLows != 1) $display("[TB] FAIL burstEopWidth: %0d low cycles required 1", eopLows); else passCount++;
    checkCount++;
    if (grantLeak) $display("[TB] FAIL burstGrant: bgrt_ went low with breq_ high, required 1"); else passCount++;
    modelCopy(10'h150, 10'h160, 4);
    acquireBus();
    for (int i = 0; i < 8; i++) begin
      cpuRead(10'h160 + 10'(i), rd);
      checkCount++;
      if (rd !== model[10'h160 + 10'(i)])
        $display("[TB] FAIL burstData[%0d]: odata=%h required %h", i, rd, model[10'h160 + 10'(i)]);
      else passCount++;
    end
    releaseBus();
  endtask

  task automatic test_breq_mid_burst();
    logic [9:0] s;
    logic [9:0] d;
    logic [7:0] rd;
    int eopAt;
    int grantAt;
    s = 10'($urandom);
    d = s + 10'(16 + $urandom_range(0, 900));
    acquireBus();
    for (int i = 0; i < 4; i++) begin
      cpuWrite(s + 10'(i), 8'($urandom));
      cpuWrite(d + 10'(i), 8'($urandom));
    end
    releaseBus();
    pulseDreq(s, d, 2'b01);
    eopAt = -1;
    grantAt = -1;
    for (int k = 2; k <= 14; k++) begin
      if (k == 3) breq_ = 1'b0;
      tick();
      if (eop_ === 1'b0 && eopAt < 0) eopAt = k;
      if (bgrt_ === 1'b0 && grantAt < 0) grantAt = k;
    end
    checkCount++;
    if (eopAt != 10) $display("[TB] FAIL preemptEop: eop_ low at cycle %0d required 10", eopAt); else passCount++;
    checkCount++;
    if (grantAt != 11) $display("[TB] FAIL preemptGrant: bgrt_ low at cycle %0d required 11", grantAt); else passCount++;
    modelCopy(s, d, 4);
    for (int i = 0; i < 4; i++) begin
      cpuRead(d + 10'(i), rd);
      checkCount++;
      if (rd !== model[d + 10'(i)])
        $display("[TB] FAIL preemptData[%0d]: odata=%h required %h", i, rd, model[d + 10'(i)]);
      else passCount++;
    end
    releaseBus();
  endtask

  task automatic test_single();
    logic [7:0] rd;
    int eopAt;
    acquireBus();
    for (int i = 0; i < 5; i++) cpuWrite(10'h170 + 10'(i), 8'($urandom));
    releaseBus();
    for (int p = 0; p < 4; p++) begin
      if (p == 2) begin
        // Request arrives while the processor owns the bus: it must wait.
        acquireBus();
        pulseDreq(10'($urandom), 10'($urandom), 2'($urandom));
        repeat (4) tick();
        cpuRead(10'h172, rd);
        checkCount++;
        if (rd !== model[10'h172])
          $display("[TB] FAIL singleWaitsForCpu: odata=%h required %h", rd, model[10'h172]);
        else passCount++;
        releaseBus();
      end else if (p == 0) begin
        pulseDreq(10'h150, 10'h170, 2'b00);
      end else begin
        pulseDreq(10'($urandom), 10'($urandom), 2'($urandom));
      end
      eopAt = -1;
      for (int k = 2; k <= 8; k++) begin
        tick();
        if (eop_ === 1'b0 && eopAt < 0) eopAt = k;
      end
      checkCount++;
      if (p == 3 && eopAt != 4)
        $display("[TB] FAIL singleEop[%0d]: eop_ low at cycle %0d required 4", p, eopAt);
      else if (p != 3 && p != 2 && eopAt != -1)
        $display("[TB] FAIL singleEop[%0d]: eop_ low at cycle %0d required none", p, eopAt);
      else if (p == 2 && eopAt != -1)
        $display("[TB] FAIL singleEop[%0d]: eop_ low at cycle %0d required none", p, eopAt);
      else passCount++;
      modelCopy(10'h150 + 10'(p), 10'h170 + 10'(p), 1);
      acquireBus();
      cpuRead(10'h170 + 10'(p), rd);
      checkCount++;
      if (rd !== model[10'h170 + 10'(p)])
        $display("[TB] FAIL singleData[%0d]: odata=%h required %h", p, rd, model[10'h170 + 10'(p)]);
      else passCount++;
      cpuRead(10'h171 + 10'(p), rd);
      checkCount++;
      if (rd !== model[10'h171 + 10'(p)])
        $display("[TB] FAIL singleNext[%0d]: odata=%h required %h", p, rd, model[10'h171 + 10'(p)]);
      else passCount++;
      releaseBus();
    end
  endtask

  task automatic test_reserved();
    logic [7:0] rd;
    int eopLows;
    acquireBus();
    for (int i = 0; i < 4; i++) cpuWrite(10'h1A0 + 10'(i), 8'($urandom));
    releaseBus();
    for (int m = 2; m <= 3; m++) begin
      pulseDreq(10'h150, 10'h1A0, 2'(m));
      eopLows = 0;
      for (int k = 2; k <= 13; k++) begin
        tick();
        if (eop_ === 1'b0) eopLows++;
      end
      checkCount++;
      if (eopLows != 0) $display("[TB] FAIL reservedEop[%0d]: %0d low cycles required 0", m, eopLows); else passCount++;
    end
    acquireBus();
    for (int i = 0; i < 4; i++) begin
      cpuRead(10'h1A0 + 10'(i), rd);
      checkCount++;
      if (rd !== model[10'h1A0 + 10'(i)])
        $display("[TB] FAIL reservedData[%0d]: odata=%h required %h", i, rd, model[10'h1A0 + 10'(i)]);
      else passCount++;
    end
    releaseBus();
  endtask

  task automatic test_wrap_reset();
    logic [7:0] rd;
    int eopAt;
    int eopLows;
    acquireBus();
    cpuWrite(10'h3FE, 8'($urandom));
    cpuWrite(10'h3FF, 8'($urandom));
    cpuWrite(10'h000, 8'($urandom));
    cpuWrite(10'h001, 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      cpuWrite(10'h200 + 10'(i), 8'($urandom));
      cpuWrite(10'h240 + 10'(i), 8'($urandom));
    end
    releaseBus();
    pulseDreq(10'h3FE, 10'h200, 2'b01);
    eopAt = -1;
    for (int k = 2; k <= 14; k++) begin
      tick();
      if (eop_ === 1'b0 && eopAt < 0) eopAt = k;
    end
    checkCount++;
    if (eopAt != 10) $display("[TB] FAIL wrapEop: eop_ low at cycle %0d required 10", eopAt); else passCount++;
    modelCopy(10'h3FE, 10'h200, 4);
    acquireBus();
    for (int i = 0; i < 4; i++) begin
      cpuRead(10'h200 + 10'(i), rd);
      checkCount++;
      if (rd !== model[10'h200 + 10'(i)])
        $display("[TB] FAIL wrapData[%0d]: odata=%h required %h", i, rd, model[10'h200 + 10'(i)]);
      else passCount++;
    end
    releaseBus();
    // Second burst is cut by reset after its first word has landed.
    pulseDreq(10'h3FE, 10'h240, 2'b01);
    repeat (4) tick();
    reset_ = 1'b0;
    #1;
    checkCount++;
    if (bgrt_ !== 1'b1) $display("[TB] FAIL abortBgrt: bgrt_=%b required 1", bgrt_); else passCount++;
    checkCount++;
    if (eop_ !== 1'b1) $display("[TB] FAIL abortEop: eop_=%b required 1", eop_); else passCount++;
    repeat (2) tick();
    reset_ = 1'b1;
    eopLows = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (eop_ === 1'b0) eopLows++;
    end
    checkCount++;
    if (eopLows != 0) $display("[TB] FAIL abortNoEop: %0d low cycles required 0", eopLows); else passCount++;
    modelCopy(10'h3FE, 10'h240, 1);
    acquireBus();
    for (int i = 0; i < 4; i++) begin
      cpuRead(10'h240 + 10'(i), rd);
      checkCount++;
      if (rd !== model[10'h240 + 10'(i)])
        $display("[TB] FAIL abortData[%0d]: odata=%h required %h", i, rd, model[10'h240 + 10'(i)]);
      else passCount++;
    end
    releaseBus();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_cpu_rw();
    test_burst();
    test_breq_mid_burst();
    test_single();
    test_reserved();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
